// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants, palette, state encodings and helpers for the LED pattern generator
package led_pkg;

    // Envelope and blink timing, in 1 ms ticks
    localparam logic [7:0] IDLE_LEVEL    = 8'd32;
    localparam logic [7:0] ATTACK_STEP   = 8'd16;
    localparam logic [7:0] DECAY_STEP    = 8'd4;
    localparam logic [8:0] BLINK_HALF_MS = 9'd500;

    // Per music key colour, channel order R, G, B
    localparam logic [7:0] PALETTE [6][3] = '{
        '{8'd255, 8'd0,   8'd0  },
        '{8'd0,   8'd255, 8'd0  },
        '{8'd0,   8'd0,   8'd255},
        '{8'd255, 8'd255, 8'd0  },
        '{8'd0,   8'd255, 8'd255},
        '{8'd255, 8'd0,   8'd255}
    };

    // Music box state encodings; anything not listed behaves as idle
    localparam logic [4:0] CS_IDLE     = 5'd0;
    localparam logic [4:0] CS_SONG0    = 5'd1;
    localparam logic [4:0] CS_SONG1    = 5'd2;
    localparam logic [4:0] CS_PLAY_REC = 5'd3;
    localparam logic [4:0] CS_MAKE_REC = 5'd4;
    localparam logic [4:0] CS_BEE      = 5'd5;

    // Mode key slots on modeKeys_RGBColor
    localparam logic [2:0] MK_SONG0    = 3'd0;
    localparam logic [2:0] MK_SONG1    = 3'd1;
    localparam logic [2:0] MK_MAKE_REC = 3'd2;
    localparam logic [2:0] MK_PLAY_REC = 3'd3;
    localparam logic [2:0] MK_BEE      = 3'd4;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_BREATHE,
        MS_BLINK
    } mode_state_e;

    // Upper byte of colour * level: full-scale level gives (almost) full colour
    function automatic logic [7:0] scale_duty(input logic [7:0] color, input logic [7:0] level);
        logic [15:0] prod;
        prod = 16'(color) * 16'(level);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/led_envelope.sv
// rtl/led_envelope.sv - per-key attack/decay brightness envelope stepped by the 1 ms tick
module led_envelope
    import led_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key,
    output logic [7:0] env
);

    logic [7:0] env_q;
    logic [7:0] env_d;

    // Saturating rise while pressed, floor at the idle glow while released
    always_comb begin
        env_d = env_q;
        if (tick) begin
            if (key) begin
                env_d = (env_q > (8'd255 - ATTACK_STEP)) ? 8'd255 : env_q + ATTACK_STEP;
            end else begin
                env_d = (env_q < (IDLE_LEVEL + DECAY_STEP)) ? IDLE_LEVEL : env_q - DECAY_STEP;
            end
        end
    end

    // Envelope register
    always_ff @(posedge clk) begin
        if (reset) begin
            env_q <= IDLE_LEVEL;
        end else begin
            env_q <= env_d;
        end
    end

    assign env = env_q;

endmodule

// File: rtl/led_pattern_generator.sv
// rtl/led_pattern_generator.sv - music key envelopes and mode key breathe/blink patterns
module led_pattern_generator
    import led_pkg::*;
(
    input  logic                  CLK_50Mhz,
    input  logic                  reset,
    input  logic                  CLK_1Khz,
    input  logic [4:0]            currentState,
    input  logic [5:0]            input_MusicKey,
    output logic [5:0][2:0][7:0]  musicKeys_RGBColor,
    output logic [4:0][7:0]       modeKeys_RGBColor
);

    logic [2:0]           sync_q, sync_d;
    logic                 tick_q, tick_d;
    logic [5:0][7:0]      env;
    logic [5:0][2:0][7:0] mus_q, mus_d;
    mode_state_e          state_q, state_d;
    logic [2:0]           key_q, key_d;
    logic [4:0]           prev_cs_q, prev_cs_d;
    logic [7:0]           tri_cnt_q, tri_cnt_d;
    logic                 tri_down_q, tri_down_d;
    logic [8:0]           ms_q, ms_d;
    logic                 blink_on_q, blink_on_d;
    logic [4:0][7:0]      mode_q, mode_d;

    // Two synchronizer stages plus one history bit; tick marks a synchronized rising edge
    always_comb begin
        sync_d = {sync_q[1:0], CLK_1Khz};
        tick_d = sync_q[1] & ~sync_q[2];
    end

    for (genvar k = 0; k < 6; k++) begin : g_env
        led_envelope u_env (
            .clk   (CLK_50Mhz),
            .reset (reset),
            .tick  (tick_q),
            .key   (input_MusicKey[k]),
            .env   (env[k])
        );
    end

    // Music outputs: palette colour scaled by each key's envelope
    always_comb begin
        mus_d = '0;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 3; c++) begin
                mus_d[k][c] = scale_duty(PALETTE[k][c], env[k]);
            end
        end
    end

    // Mode decode and pattern counters; a state change restarts counters ahead of any tick advance
    always_comb begin
        prev_cs_d = currentState;
        state_d   = MS_IDLE;
        key_d     = MK_SONG0;
        case (currentState)
            CS_SONG0:    begin state_d = MS_BREATHE; key_d = MK_SONG0;    end
            CS_SONG1:    begin state_d = MS_BREATHE; key_d = MK_SONG1;    end
            CS_PLAY_REC: begin state_d = MS_BREATHE; key_d = MK_PLAY_REC; end
            CS_BEE:      begin state_d = MS_BREATHE; key_d = MK_BEE;      end
            CS_MAKE_REC: begin state_d = MS_BLINK;   key_d = MK_MAKE_REC; end
            default:     begin state_d = MS_IDLE;    key_d = MK_SONG0;    end
        endcase

        tri_cnt_d  = tri_cnt_q;
        tri_down_d = tri_down_q;
        ms_d       = ms_q;
        blink_on_d = blink_on_q;
        if (currentState != prev_cs_q) begin
            tri_cnt_d  = 8'd0;
            tri_down_d = 1'b0;
            ms_d       = 9'd0;
            blink_on_d = 1'b1;
        end else if (tick_q) begin
            if (!tri_down_q) begin
                if (tri_cnt_q == 8'd255) begin
                    tri_down_d = 1'b1;
                    tri_cnt_d  = 8'd254;
                end else begin
                    tri_cnt_d = tri_cnt_q + 8'd1;
                end
            end else begin
                if (tri_cnt_q == 8'd0) begin
                    tri_down_d = 1'b0;
                    tri_cnt_d  = 8'd1;
                end else begin
                    tri_cnt_d = tri_cnt_q - 8'd1;
                end
            end
            if (ms_q == BLINK_HALF_MS - 9'd1) begin
                ms_d       = 9'd0;
                blink_on_d = ~blink_on_q;
            end else begin
                ms_d = ms_q + 9'd1;
            end
        end
    end

    // Mode key outputs: idle glow everywhere except the one active key
    always_comb begin
        mode_d = '0;
        for (int i = 0; i < 5; i++) begin
            mode_d[i] = IDLE_LEVEL;
            if (key_q == 3'(i)) begin
                case (state_q)
                    MS_BREATHE: mode_d[i] = tri_cnt_q;
                    MS_BLINK:   mode_d[i] = blink_on_q ? 8'hFF : 8'h00;
                    default:    mode_d[i] = IDLE_LEVEL;
                endcase
            end
        end
    end

    // All state registers
    always_ff @(posedge CLK_50Mhz) begin
        if (reset) begin
            sync_q     <= '0;
            tick_q     <= 1'b0;
            mus_q      <= '0;
            state_q    <= MS_IDLE;
            key_q      <= MK_SONG0;
            prev_cs_q  <= CS_IDLE;
            tri_cnt_q  <= 8'd0;
            tri_down_q <= 1'b0;
            ms_q       <= 9'd0;
            blink_on_q <= 1'b1;
            mode_q     <= '0;
        end else begin
            sync_q     <= sync_d;
            tick_q     <= tick_d;
            mus_q      <= mus_d;
            state_q    <= state_d;
            key_q      <= key_d;
            prev_cs_q  <= prev_cs_d;
            tri_cnt_q  <= tri_cnt_d;
            tri_down_q <= tri_down_d;
            ms_q       <= ms_d;
            blink_on_q <= blink_on_d;
            mode_q     <= mode_d;
        end
    end

    assign musicKeys_RGBColor = mus_q;
    assign modeKeys_RGBColor  = mode_q;

endmodule

// File: tb/tb_led_pattern_generator.sv
// tb/tb_led_pattern_generator.sv - self-checking bench for led_pattern_generator
module tb_led_pattern_generator;

    logic                 CLK_50Mhz = 1'b0;
    logic                 reset;
    logic                 CLK_1Khz;
    logic [4:0]           currentState;
    logic [5:0]           input_MusicKey;
    logic [5:0][2:0][7:0] musicKeys_RGBColor;
    logic [4:0][7:0]      modeKeys_RGBColor;

    always #10 CLK_50Mhz = ~CLK_50Mhz;

    led_pattern_generator dut (
        .CLK_50Mhz          (CLK_50Mhz),
        .reset              (reset),
        .CLK_1Khz           (CLK_1Khz),
        .currentState       (currentState),
        .input_MusicKey     (input_MusicKey),
        .musicKeys_RGBColor (musicKeys_RGBColor),
        .modeKeys_RGBColor  (modeKeys_RGBColor)
    );

    typedef struct {
        string      name;
        logic [4:0] cs;
        logic [5:0] keys;
        int         ticks;
        int         sel;
        int         expv;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;
    int   pal [6][3] = '{'{255,0,0}, '{0,255,0}, '{0,0,255},
                         '{255,255,0}, '{0,255,255}, '{255,0,255}};
    int   menv [6];

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [4:0] cs, input logic [5:0] keys,
                           input int ticks, input int sel, input int expv);
        vec_t v;
        v.name = name; v.cs = cs; v.keys = keys; v.ticks = ticks; v.sel = sel; v.expv = expv;
        tbl.push_back(v);
    endtask

    // One 1 kHz period compressed to 8 system clocks; optional state change and key glitch inside it
    task automatic do_tick(input int chg_at, input logic [4:0] chg_cs, input logic [5:0] glitch);
        logic [5:0] held;
        held = input_MusicKey;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) CLK_1Khz = 1'b1;
            if (i == 4) CLK_1Khz = 1'b0;
            if (i == chg_at) currentState = chg_cs;
            if (i == 5) input_MusicKey = held | glitch;
            if (i == 7) input_MusicKey = held;
            @(negedge CLK_50Mhz);
        end
    endtask

    function automatic logic [7:0] get_out(input int sel);
        if (sel < 18) return musicKeys_RGBColor[sel / 3][sel % 3];
        return modeKeys_RGBColor[sel - 18];
    endfunction

    function automatic logic [5:0][2:0][7:0] mus_model();
        logic [5:0][2:0][7:0] r;
        for (int k = 0; k < 6; k++)
            for (int c = 0; c < 3; c++)
                r[k][c] = 8'((pal[k][c] * menv[k]) / 256);
        return r;
    endfunction

    // Pattern as a function of ticks elapsed since the last state change
    function automatic logic [4:0][7:0] mode_model(input logic [4:0] cs, input int n);
        logic [4:0][7:0] r;
        int m;
        logic [7:0] tri_v;
        m = n % 510;
        tri_v = (m <= 255) ? 8'(m) : 8'(510 - m);
        for (int i = 0; i < 5; i++) r[i] = 8'd32;
        case (cs)
            5'd1: r[0] = tri_v;
            5'd2: r[1] = tri_v;
            5'd3: r[3] = tri_v;
            5'd5: r[4] = tri_v;
            5'd4: r[2] = (((n / 500) % 2) == 0) ? 8'd255 : 8'd0;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] mcs, ncs;
        logic [5:0] keys;
        int n;

        reset = 1'b1; CLK_1Khz = 1'b0; currentState = 5'd0; input_MusicKey = 6'd0;
        for (int i = 0; i < 6; i++) menv[i] = 32;
        repeat (3) @(negedge CLK_50Mhz);
        check("reset_music", 144'(musicKeys_RGBColor), 144'd0);
        check("reset_mode", 144'(modeKeys_RGBColor), 144'd0);
        reset = 1'b0;
        @(negedge CLK_50Mhz);
        check("first_cycle_music", 144'(musicKeys_RGBColor), 144'(mus_model()));
        check("first_cycle_mode", 144'(modeKeys_RGBColor), 144'(mode_model(5'd0, 0)));

        add_vec("idle_k0_r",     5'd0, 6'd0, 0,   0,  31);
        add_vec("idle_k3_r",     5'd0, 6'd0, 0,   9,  31);
        add_vec("idle_k3_g",     5'd0, 6'd0, 0,   10, 31);
        add_vec("idle_k3_b",     5'd0, 6'd0, 0,   11, 0);
        add_vec("idle_song0",    5'd0, 6'd0, 0,   18, 32);
        add_vec("idle_bee",      5'd0, 6'd0, 0,   22, 32);
        add_vec("attack_1",      5'd0, 6'd1, 1,   0,  47);
        add_vec("attack_14",     5'd0, 6'd1, 13,  0,  254);
        add_vec("attack_hold",   5'd0, 6'd1, 5,   0,  254);
        add_vec("attack_k0_g",   5'd0, 6'd1, 0,   1,  0);
        add_vec("decay_55",      5'd0, 6'd0, 55,  0,  34);
        add_vec("decay_56",      5'd0, 6'd0, 1,   0,  31);
        add_vec("decay_hold",    5'd0, 6'd0, 10,  0,  31);
        add_vec("song0_t1",      5'd1, 6'd0, 1,   18, 1);
        add_vec("song0_t255",    5'd1, 6'd0, 254, 18, 255);
        add_vec("song0_t510",    5'd1, 6'd0, 255, 18, 0);
        add_vec("song0_other",   5'd1, 6'd0, 0,   19, 32);
        add_vec("blink_t499",    5'd4, 6'd0, 499, 20, 255);
        add_vec("blink_t500",    5'd4, 6'd0, 1,   20, 0);
        add_vec("blink_t700",    5'd4, 6'd0, 200, 20, 0);
        add_vec("blink_song0",   5'd4, 6'd0, 0,   18, 32);

        foreach (tbl[i]) begin
            currentState = tbl[i].cs;
            input_MusicKey = tbl[i].keys;
            for (int t = 0; t < tbl[i].ticks; t++) do_tick(-1, 5'd0, 6'd0);
            repeat (2) @(negedge CLK_50Mhz);
            check(tbl[i].name, 144'(get_out(tbl[i].sel)), 144'(tbl[i].expv));
        end

        // Leaving blink: output holds one more cycle, then idle level two cycles after the change
        currentState = 5'd0;
        @(negedge CLK_50Mhz);
        check("makerec_lag1", 144'(modeKeys_RGBColor[2]), 144'd0);
        @(negedge CLK_50Mhz);
        check("makerec_idle_2cyc", 144'(modeKeys_RGBColor[2]), 144'd32);

        // Song0 -> Song1 on the same cycle as a tick
        currentState = 5'd1;
        for (int t = 0; t < 100; t++) do_tick(-1, 5'd0, 6'd0);
        check("song0_at_100", 144'(modeKeys_RGBColor[0]), 144'd100);
        do_tick(3, 5'd2, 6'd0);
        check("switch_song0_idle", 144'(modeKeys_RGBColor[0]), 144'd32);
        check("switch_song1_zero", 144'(modeKeys_RGBColor[1]), 144'd0);
        do_tick(-1, 5'd0, 6'd0);
        check("switch_song1_next", 144'(modeKeys_RGBColor[1]), 144'd1);

        // Reset mid-attack and mid-pattern leaves nothing behind
        input_MusicKey = 6'd1;
        for (int t = 0; t < 3; t++) do_tick(-1, 5'd0, 6'd0);
        reset = 1'b1;
        @(negedge CLK_50Mhz);
        check("midrun_reset_music", 144'(musicKeys_RGBColor), 144'd0);
        check("midrun_reset_mode", 144'(modeKeys_RGBColor), 144'd0);
        currentState = 5'd0; input_MusicKey = 6'd0;
        @(negedge CLK_50Mhz);
        reset = 1'b0;
        @(negedge CLK_50Mhz);
        check("post_reset_music", 144'(musicKeys_RGBColor), 144'(mus_model()));
        check("post_reset_mode", 144'(modeKeys_RGBColor), 144'(mode_model(5'd0, 0)));

        // Press and release entirely between ticks is invisible
        input_MusicKey = 6'd0;
        do_tick(-1, 5'd0, 6'b000011);
        check("glitch_ignored", 144'(musicKeys_RGBColor), 144'(mus_model()));

        // Randomized run against the tick-level reference model
        mcs = 5'd0; n = 0; keys = 6'd0;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 15) == 0) begin
                ncs = 5'($urandom_range(0, 7));
                if (ncs != mcs) n = 0;
                mcs = ncs;
            end
            if ($urandom_range(0, 7) == 0) keys = 6'($urandom);
            currentState = mcs;
            input_MusicKey = keys;
            do_tick(-1, 5'd0, 6'd0);
            n++;
            for (int k = 0; k < 6; k++) begin
                if (keys[k]) menv[k] = (menv[k] + 16 > 255) ? 255 : menv[k] + 16;
                else         menv[k] = (menv[k] - 4 < 32) ? 32 : menv[k] - 4;
            end
            check("rand_music", 144'(musicKeys_RGBColor), 144'(mus_model()));
            check("rand_mode", 144'(modeKeys_RGBColor), 144'(mode_model(mcs, n)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
